flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit_if.sv | 36 +++
 rtl/flag_unit.sv | 96 +++++++++
 tb/tb_flag_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/flag_unit_if.sv
// flag_unit_if: groups the flag unit's update, query and flag-output signals.
// The save/restore pins exist only when FLAG_SHADOW_EN is defined.
interface flag_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] res;
    logic             carry_in;
    logic             ovf_in;
    logic             upd_en;
    logic             cond_req;
    logic [2:0]       cond_sel;
    logic             flush;
    logic [3:0]       flags;
    logic             cond_valid;
    logic             cond_take;
`ifdef FLAG_SHADOW_EN
    logic             save;
    logic             restore;
`endif

    modport master (
        output res, carry_in, ovf_in, upd_en, cond_req, cond_sel, flush,
`ifdef FLAG_SHADOW_EN
        output save, restore,
`endif
        input  flags, cond_valid, cond_take
    );

    modport slave (
        input  res, carry_in, ovf_in, upd_en, cond_req, cond_sel, flush,
`ifdef FLAG_SHADOW_EN
        input  save, restore,
`endif
        output flags, cond_valid, cond_take
    );
endinterface

// File: rtl/flag_unit.sv
// flag_unit: registered {Z,N,C,V} flags plus a one-cycle branch-condition query port.
// Defining FLAG_SHADOW_EN adds a 4-bit shadow register with save/restore.
module flag_unit #(
    parameter int WIDTH     = 32,
    parameter bit ZERO_ONLY = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    flag_unit_if.slave   bus
);
    typedef enum logic [2:0] {
        COND_AL = 3'd0,
        COND_EQ = 3'd1,
        COND_NE = 3'd2,
        COND_MI = 3'd3,
        COND_PL = 3'd4,
        COND_CS = 3'd5,
        COND_CC = 3'd6,
        COND_VS = 3'd7
    } cond_e;

    logic [3:0] r_flags;
    logic       r_valid;
    logic       r_take;
    logic [3:0] w_upd_flags;
    logic [3:0] w_next_flags;
    logic       w_cond_hit;
    logic       w_accept;

`ifdef FLAG_SHADOW_EN
    logic [3:0] r_shadow;
`endif

    always_comb begin
        w_upd_flags[3] = (bus.res == '0);
        w_upd_flags[2] = ZERO_ONLY ? 1'b0 : bus.res[WIDTH-1];
        w_upd_flags[1] = ZERO_ONLY ? 1'b0 : bus.carry_in;
        w_upd_flags[0] = ZERO_ONLY ? 1'b0 : bus.ovf_in;
    end

    // Queries evaluate against the flags as they will be after this edge.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_next_flags = r_flags;
        if (bus.upd_en)
            w_next_flags = w_upd_flags;
`ifdef FLAG_SHADOW_EN
        if (bus.restore)
            w_next_flags = r_shadow;
`endif
    end

    always_comb begin
        w_cond_hit = 1'b0;
        case (cond_e'(bus.cond_sel))
            COND_AL: w_cond_hit = 1'b1;
            COND_EQ: w_cond_hit = w_next_flags[3];
            COND_NE: w_cond_hit = ~w_next_flags[3];
            COND_MI: w_cond_hit = w_next_flags[2];
            COND_PL: w_cond_hit = ~w_next_flags[2];
            COND_CS: w_cond_hit = w_next_flags[1];
            COND_CC: w_cond_hit = ~w_next_flags[1];
            COND_VS: w_cond_hit = w_next_flags[0];
            default: w_cond_hit = 1'b0;
        endcase
    end

    assign w_accept = bus.cond_req & ~bus.flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 4'b0000;
            r_valid <= 1'b0;
            r_take  <= 1'b0;
        end else begin
            r_flags <= w_next_flags;
            r_valid <= w_accept;
            r_take  <= w_accept & w_cond_hit;
        end
    end

`ifdef FLAG_SHADOW_EN
    // Save captures the pre-edge flags, so save+restore together swaps.
    always_ff @(posedge clk) begin
        if (rst)
            r_shadow <= 4'b0000;
        else if (bus.save)
            r_shadow <= r_flags;
    end
`endif

    assign bus.flags      = r_flags;
    assign bus.cond_valid = r_valid;
    assign bus.cond_take  = r_take;
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed and random stimulus on a 32-bit and an 8-bit ZERO_ONLY flag unit,
// checked against a behavioural model of flags, shadow and query results.
module tb_flag_unit;
    logic clk;
    logic rst;

    flag_unit_if #(.WIDTH(32)) bus ();
    flag_unit_if #(.WIDTH(8))  bus_z ();

    flag_unit #(.WIDTH(32), .ZERO_ONLY(1'b0)) dut   (.clk(clk), .rst(rst), .bus(bus));
    flag_unit #(.WIDTH(8),  .ZERO_ONLY(1'b1)) dut_z (.clk(clk), .rst(rst), .bus(bus_z));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] flags;
        logic [3:0] shadow;
        logic       valid;
        logic       take;
    } model_t;

    model_t m32;
    model_t m8;

    int n_vec;
    int n_err;

    logic [31:0] t_res;
    logic [7:0]  t_res8;
    logic        t_rst, t_carry, t_ovf, t_upd, t_req, t_flush, t_save, t_restore;
    logic [2:0]  t_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock of behaviour: flags {Z,N,C,V}; restore beats update; query sees post-edge flags.
    function automatic model_t model_next(input model_t m, input bit rst_i, input bit upd,
                                          input bit z, input bit n, input bit c, input bit v,
                                          input bit req, input logic [2:0] sel, input bit fl,
                                          input bit sv, input bit rs);
        model_t r;
        bit     truth [8];
        r = m;
        if (rst_i) begin
            r.flags  = 4'b0000;
            r.shadow = 4'b0000;
            r.valid  = 1'b0;
            r.take   = 1'b0;
            return r;
        end
        if (rs)
            r.flags = m.shadow;
        else if (upd)
            r.flags = {z, n, c, v};
        if (sv)
            r.shadow = m.flags;
        truth = '{1'b1, r.flags[3], !r.flags[3], r.flags[2], !r.flags[2],
                  r.flags[1], !r.flags[1], r.flags[0]};
        r.valid = req && !fl;
        r.take  = r.valid && truth[sel];
        return r;
    endfunction

    task automatic idle();
        t_rst = 0; t_res = 32'h1; t_res8 = 8'h1; t_carry = 0; t_ovf = 0;
        t_upd = 0; t_req = 0; t_sel = 3'd0; t_flush = 0; t_save = 0; t_restore = 0;
    endtask

    task automatic cycle();
        rst          = t_rst;
        bus.res      = t_res;      bus_z.res      = t_res8;
        bus.carry_in = t_carry;    bus_z.carry_in = t_carry;
        bus.ovf_in   = t_ovf;      bus_z.ovf_in   = t_ovf;
        bus.upd_en   = t_upd;      bus_z.upd_en   = t_upd;
        bus.cond_req = t_req;      bus_z.cond_req = t_req;
        bus.cond_sel = t_sel;      bus_z.cond_sel = t_sel;
        bus.flush    = t_flush;    bus_z.flush    = t_flush;
`ifdef FLAG_SHADOW_EN
        bus.save     = t_save;     bus_z.save     = t_save;
        bus.restore  = t_restore;  bus_z.restore  = t_restore;
`else
        t_save = 0; t_restore = 0;
`endif
        m32 = model_next(m32, t_rst, t_upd, (t_res == 0), t_res[31], t_carry, t_ovf,
                         t_req, t_sel, t_flush, t_save, t_restore);
        m8  = model_next(m8, t_rst, t_upd, (t_res8 == 0), 1'b0, 1'b0, 1'b0,
                         t_req, t_sel, t_flush, t_save, t_restore);
        @(posedge clk);
        #1;
        check("flags32", 32'(bus.flags), 32'(m32.flags));
        check("valid32", 32'(bus.cond_valid), 32'(m32.valid));
        check("take32",  32'(bus.cond_take), 32'(m32.take));
        check("flags8",  32'(bus_z.flags), 32'(m8.flags));
        check("valid8",  32'(bus_z.cond_valid), 32'(m8.valid));
        check("take8",   32'(bus_z.cond_take), 32'(m8.take));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m32 = '{flags: 4'b0, shadow: 4'b0, valid: 1'b0, take: 1'b0};
        m8  = '{flags: 4'b0, shadow: 4'b0, valid: 1'b0, take: 1'b0};
        idle();

        // Reset state
        t_rst = 1; t_upd = 1; t_res = 0; t_req = 1;
        cycle();
        cycle();
        check("rst_flags", 32'(bus.flags), 32'h0);
        check("rst_valid", 32'(bus.cond_valid), 32'h0);

        // Zero and negative detect
        idle(); t_upd = 1; t_res = 32'h0;
        cycle();
        check("zero_flags", 32'(bus.flags), 32'h8);
        idle(); t_upd = 1; t_res = 32'h8000_0000;
        cycle();
        check("neg_flags", 32'(bus.flags), 32'h4);
        idle();
        cycle();
        check("hold_flags", 32'(bus.flags), 32'h4);

        // Forwarding: Z is 0, same-cycle update makes it 1 and the query sees it
        idle(); t_upd = 1; t_res = 0; t_req = 1; t_sel = 3'd1;
        cycle();
        check("fwd_valid", 32'(bus.cond_valid), 32'h1);
        check("fwd_take", 32'(bus.cond_take), 32'h1);

        // Back-to-back queries with flags 4'b0010
        idle(); t_upd = 1; t_res = 32'h1; t_carry = 1;
        cycle();
        check("b2b_setup", 32'(bus.flags), 32'h2);
        for (int i = 0; i < 3; i++) begin
            idle(); t_req = 1;
            t_sel = (i == 0) ? 3'd2 : (i == 1) ? 3'd5 : 3'd0;
            cycle();
            check("b2b_valid", 32'(bus.cond_valid), 32'h1);
            check("b2b_take", 32'(bus.cond_take), 32'h1);
        end

        // Flush cancels the same-cycle request and leaves flags alone
        idle(); t_req = 1; t_sel = 3'd0; t_flush = 1;
        cycle();
        check("flush_valid", 32'(bus.cond_valid), 32'h0);
        check("flush_take", 32'(bus.cond_take), 32'h0);
        check("flush_flags", 32'(bus.flags), 32'h2);

        // Reset mid-operation
        idle(); t_req = 1; cycle();
        idle(); t_rst = 1; t_req = 1; t_upd = 1; t_res = 0;
        cycle();
        check("midrst_flags", 32'(bus.flags), 32'h0);
        check("midrst_valid", 32'(bus.cond_valid), 32'h0);

        // ZERO_ONLY instance holds N, C and V at 0
        idle(); t_upd = 1; t_res8 = 8'hFF; t_carry = 1; t_ovf = 1;
        cycle();
        check("zo_ff", 32'(bus_z.flags), 32'h0);
        idle(); t_upd = 1; t_res8 = 8'h00; t_carry = 1;
        cycle();
        check("zo_zero", 32'(bus_z.flags), 32'h8);

`ifdef FLAG_SHADOW_EN
        idle(); t_upd = 1; t_res = 0; t_carry = 1;
        cycle();
        check("sh_setup", 32'(bus.flags), 32'hA);
        idle(); t_save = 1; cycle();
        idle(); t_upd = 1; t_res = 32'h1; cycle();
        check("sh_upd", 32'(bus.flags), 32'h0);
        idle(); t_restore = 1; t_upd = 1; t_res = 32'h8000_0000; t_req = 1; t_sel = 3'd1;
        cycle();
        check("sh_restore", 32'(bus.flags), 32'hA);
        check("sh_fwd_take", 32'(bus.cond_take), 32'h1);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            idle();
            t_rst = ($urandom_range(0, 63) == 0);
            case ($urandom_range(0, 3))
                0:       t_res = 32'h0;
                1:       t_res = 32'h8000_0000 | ($urandom() & 32'hFF);
                default: t_res = $urandom();
            endcase
            t_res8    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            t_carry   = 1'($urandom());
            t_ovf     = 1'($urandom());
            t_upd     = ($urandom_range(0, 2) == 0);
            t_req     = ($urandom_range(0, 3) != 0);
            t_sel     = 3'($urandom());
            t_flush   = ($urandom_range(0, 7) == 0);
            t_save    = ($urandom_range(0, 7) == 0);
            t_restore = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
